oram_frontend_arbiter: RTL and testbench
========================================

Name: oram_frontend_arbiter

Overview:
Shares the single TinyORAMCore frontend port (Cmd/PAddr plus DataIn/DataOut chunk streams) among NumReq independent requesters. It grants one requester at a time by round-robin, forwards its command, and then sequences the whole data phase before releasing the port. In a write phase it moves FEORAMBChunks beats in; in a read phase it steers FEORAMBChunks return beats to the granted requester. It sits between the network/client interfaces and TinyORAMCore.

Parameters:
NumReq, 2, number of requesters (2..4)
ORAMB, 512, ORAM block size in bits
ORAMU, 32, program address width
FEDWidth, 64, frontend data beat width; FEORAMBChunks = ORAMB/FEDWidth (8 by default)

Ports:
Clock  in  1  clock
Reset  in  1  synchronous, active-low reset
Req_Cmd  in  2*NumReq  per-requester command (0 Update, 1 Append, 2 Read, 3 ReadRmv)
Req_PAddr  in  ORAMU*NumReq  per-requester address
Req_CmdValid  in  NumReq  command valid
Req_CmdReady  out  NumReq  command accepted (one-hot pulse)
Req_DataIn  in  FEDWidth*NumReq  write beats
Req_DataInValid  in  NumReq  write beat valid
Req_DataInReady  out  NumReq  write beat accepted
Req_DataOut  out  FEDWidth  return beat, broadcast to all requesters
Req_DataOutValid  out  NumReq  return beat valid, asserted only for the granted requester
Req_DataOutReady  in  NumReq  return beat ready
Cmd  out  2  to ORAM
PAddr  out  ORAMU  to ORAM
CmdValid  out  1  to ORAM
CmdReady  in  1  from ORAM
DataIn  out  FEDWidth  to ORAM
DataInValid  out  1  to ORAM
DataInReady  in  1  from ORAM
DataOut  in  FEDWidth  from ORAM
DataOutValid  in  1  from ORAM
DataOutReady  out  1  to ORAM
Grant  out  NumReq  one-hot owner, zero when idle
Busy  out  1  high in any state other than ST_Idle

Behaviour:
- Reset (Reset==0 at posedge): state ST_Idle, Grant=0, RR pointer=0 (requester 0 has highest priority), beat counter=0. CmdValid, DataInValid, DataOutReady, all Req_*Ready and Req_DataOutValid are 0. Cmd and PAddr are 0.
- ST_Idle:
  - If any Req_CmdValid is set, pick the first valid index starting at (last grant + 1) mod NumReq.
  - Pulse Req_CmdReady[w] for exactly one cycle. That pulse is combinational in the same cycle as the pick; the pick is made from that cycle's inputs.
  - Latch Cmd, PAddr and Grant=onehot(w). Set last grant = w. Go to ST_Cmd.
- ST_Cmd:
  - CmdValid=1 with the latched values, held stable until CmdReady.
  - On CmdValid&&CmdReady: Cmd 0/1 goes to ST_WrData; Cmd 2/3 goes to ST_RdData. The beat counter clears.
  - Minimum latency from request acceptance to CmdValid is 1 cycle.
- ST_WrData:
  - DataIn = Req_DataIn[g]. DataInValid = Req_DataInValid[g]. Req_DataInReady[g] = DataInReady. All other Req_DataInReady are 0.
  - The counter increments on each transfer. At FEORAMBChunks transfers, go to ST_Idle.
- ST_RdData:
  - Req_DataOut = DataOut. Req_DataOutValid[g] = DataOutValid. DataOutReady = Req_DataOutReady[g].
  - The counter increments on each transfer. At FEORAMBChunks transfers, go to ST_Idle.
- Outside their respective states, DataInValid, DataOutReady, Req_DataInReady and Req_DataOutValid are forced to 0. ORAM beats never leak to a non-granted requester.
- Counter width is clog2(FEORAMBChunks+1). It never wraps: the state exits exactly at the terminal count.
- Grant holds for the full command plus data phase. No preemption. New requests from any requester stay pending, with Req_CmdReady=0.
- Returning to ST_Idle takes 1 cycle. The earliest next Req_CmdReady is the cycle after the last beat.
- A requester that drops Req_CmdValid while not yet granted is simply skipped.
- Reset mid-operation aborts immediately to the reset state. The ORAM is reset from the same source, so no cleanup handshake is required.

Decomposition:
- Shared package/header (CommandsLocal.vh): BECMD_Update/Append/Read/ReadRmv encodings, and arbiter state encodings ST_Idle/ST_Cmd/ST_WrData/ST_RdData.
- One sub-module: rr_arbiter, a parameterised round-robin picker. Inputs are the request vector and the last-grant pointer. Outputs are the one-hot winner and its index.

Test Plan:
1. Reset low 5 cycles, then R0 Append addr 5 with beats 5..12 → ORAM sees CmdValid 1 cycle after Req_CmdReady[0] and exactly 8 DataIn beats 5..12. Grant=01 throughout; Busy falls after beat 8.
2. R0 and R1 both Read in the same cycle after reset → R0 is granted first. R1 is granted on the cycle after R0's 8th return beat. Req_DataOutValid[1] stays 0 during R0's beats.
3. Both requesters issue continuous Read streams for 6 accesses → grants alternate 0,1,0,1,0,1.
4. R1 Read with Req_DataOutReady[1] toggling every other cycle → DataOutReady mirrors it. All 8 beats are delivered in order and none are dropped.
5. CmdReady held low 20 cycles in ST_Cmd → Cmd/PAddr/CmdValid stay stable. No data handshake occurs until CmdReady is sampled high.
6. Reset asserted after write beat 3 of 8 → next cycle all outputs are 0, Grant=0 and Busy=0. The next request from R1 is granted with priority order restarted at 0.

Source files
------------

// File: rtl/oram_frontend_arbiter_pkg.sv
// oram_frontend_arbiter_pkg: command encodings, arbiter states and helpers shared by the frontend arbiter
package oram_frontend_arbiter_pkg;

    localparam logic [1:0] BECMD_Update  = 2'd0;
    localparam logic [1:0] BECMD_Append  = 2'd1;
    localparam logic [1:0] BECMD_Read    = 2'd2;
    localparam logic [1:0] BECMD_ReadRmv = 2'd3;

    typedef enum logic [1:0] {
        ST_Idle   = 2'd0,
        ST_Cmd    = 2'd1,
        ST_WrData = 2'd2,
        ST_RdData = 2'd3
    } arbState_t;

    function automatic logic isWriteCmd(input logic [1:0] cmd);
        return (cmd == BECMD_Update) || (cmd == BECMD_Append);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker; scans requests starting at StartPtr and returns the first hit
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         Req,
    input  logic [$clog2(N)-1:0] StartPtr,
    output logic [N-1:0]         Winner,
    output logic [$clog2(N)-1:0] WinnerIdx,
    output logic                 Any
);

    localparam int IdxW = $clog2(N);

    logic [IdxW-1:0] cand;

    always_comb begin
        Winner = '0;
        WinnerIdx = '0;
        Any = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = IdxW'((int'(StartPtr) + i) % N);
            if (!Any && Req[cand]) begin
                Any = 1'b1;
                Winner[cand] = 1'b1;
                WinnerIdx = cand;
            end
        end
    end

endmodule

// File: rtl/oram_frontend_arbiter.sv
// oram_frontend_arbiter: round-robin sharing of one ORAM frontend port; owner keeps it through command and full data phase
module oram_frontend_arbiter
    import oram_frontend_arbiter_pkg::*;
#(
    parameter int NumReq   = 2,
    parameter int ORAMB    = 512,
    parameter int ORAMU    = 32,
    parameter int FEDWidth = 64
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [2*NumReq-1:0]        Req_Cmd,
    input  logic [ORAMU*NumReq-1:0]    Req_PAddr,
    input  logic [NumReq-1:0]          Req_CmdValid,
    output logic [NumReq-1:0]          Req_CmdReady,
    input  logic [FEDWidth*NumReq-1:0] Req_DataIn,
    input  logic [NumReq-1:0]          Req_DataInValid,
    output logic [NumReq-1:0]          Req_DataInReady,
    output logic [FEDWidth-1:0]        Req_DataOut,
    output logic [NumReq-1:0]          Req_DataOutValid,
    input  logic [NumReq-1:0]          Req_DataOutReady,
    output logic [1:0]                 Cmd,
    output logic [ORAMU-1:0]           PAddr,
    output logic                       CmdValid,
    input  logic                       CmdReady,
    output logic [FEDWidth-1:0]        DataIn,
    output logic                       DataInValid,
    input  logic                       DataInReady,
    input  logic [FEDWidth-1:0]        DataOut,
    input  logic                       DataOutValid,
    output logic                       DataOutReady,
    output logic [NumReq-1:0]          Grant,
    output logic                       Busy
);

    localparam int FEORAMBChunks = ORAMB / FEDWidth;
    localparam int CntW = $clog2(FEORAMBChunks + 1);
    localparam int IdxW = $clog2(NumReq);

    arbState_t state, stateNext;
    logic [NumReq-1:0] grantNext, winner;
    logic [IdxW-1:0] gIdx, gIdxNext, rrPtr, rrPtrNext, winIdx;
    logic [1:0] cmdNext;
    logic [ORAMU-1:0] paddrNext;
    logic [CntW-1:0] beatCnt, beatCntNext;
    logic anyReq, beatFire;

    logic [1:0] cmdArr [NumReq];
    logic [ORAMU-1:0] paddrArr [NumReq];
    logic [FEDWidth-1:0] dataArr [NumReq];

    for (genvar k = 0; k < NumReq; k++) begin : g_unpack
        assign cmdArr[k] = Req_Cmd[k*2 +: 2];
        assign paddrArr[k] = Req_PAddr[k*ORAMU +: ORAMU];
        assign dataArr[k] = Req_DataIn[k*FEDWidth +: FEDWidth];
    end

    rr_arbiter #(.N(NumReq)) uArb (
        .Req      (Req_CmdValid),
        .StartPtr (rrPtr),
        .Winner   (winner),
        .WinnerIdx(winIdx),
        .Any      (anyReq)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= ST_Idle;
            Grant <= '0;
            gIdx <= '0;
            rrPtr <= '0;
            Cmd <= '0;
            PAddr <= '0;
            beatCnt <= '0;
        end else begin
            state <= stateNext;
            Grant <= grantNext;
            gIdx <= gIdxNext;
            rrPtr <= rrPtrNext;
            Cmd <= cmdNext;
            PAddr <= paddrNext;
            beatCnt <= beatCntNext;
        end
    end

    // rrPtr holds the highest-priority index for the next pick, i.e. last grant + 1
    always_comb begin
        stateNext = state;
        grantNext = Grant;
        gIdxNext = gIdx;
        rrPtrNext = rrPtr;
        cmdNext = Cmd;
        paddrNext = PAddr;
        beatCntNext = beatCnt;
        Req_CmdReady = '0;
        CmdValid = 1'b0;
        DataIn = '0;
        DataInValid = 1'b0;
        Req_DataInReady = '0;
        Req_DataOut = '0;
        Req_DataOutValid = '0;
        DataOutReady = 1'b0;
        beatFire = 1'b0;
        case (state)
            ST_Idle: begin
                if (anyReq && Reset) begin
                    Req_CmdReady = winner;
                    grantNext = winner;
                    gIdxNext = winIdx;
                    cmdNext = cmdArr[winIdx];
                    paddrNext = paddrArr[winIdx];
                    rrPtrNext = (winIdx == IdxW'(NumReq - 1)) ? '0 : winIdx + 1'b1;
                    stateNext = ST_Cmd;
                end
            end
            ST_Cmd: begin
                CmdValid = 1'b1;
                if (CmdReady) begin
                    beatCntNext = '0;
                    stateNext = isWriteCmd(Cmd) ? ST_WrData : ST_RdData;
                end
            end
            ST_WrData: begin
                DataIn = dataArr[gIdx];
                DataInValid = Req_DataInValid[gIdx];
                Req_DataInReady[gIdx] = DataInReady;
                beatFire = Req_DataInValid[gIdx] && DataInReady;
            end
            ST_RdData: begin
                Req_DataOut = DataOut;
                Req_DataOutValid[gIdx] = DataOutValid;
                DataOutReady = Req_DataOutReady[gIdx];
                beatFire = DataOutValid && Req_DataOutReady[gIdx];
            end
            default: ;
        endcase
        if (beatFire) begin
            beatCntNext = beatCnt + 1'b1;
            if (beatCnt == CntW'(FEORAMBChunks - 1)) begin
                stateNext = ST_Idle;
                grantNext = '0;
            end
        end
    end

    assign Busy = (state != ST_Idle);

endmodule

// File: tb/tb_oram_frontend_arbiter.sv
// tb_oram_frontend_arbiter: directed-step bench with hand-computed expectations for the frontend arbiter
module tb_oram_frontend_arbiter;

    localparam int NumReq = 2;
    localparam int ORAMB = 512;
    localparam int ORAMU = 32;
    localparam int FEDWidth = 64;

    logic Clock = 1'b0;
    logic Reset;
    logic [2*NumReq-1:0] Req_Cmd;
    logic [ORAMU*NumReq-1:0] Req_PAddr;
    logic [NumReq-1:0] Req_CmdValid, Req_CmdReady;
    logic [FEDWidth*NumReq-1:0] Req_DataIn;
    logic [NumReq-1:0] Req_DataInValid, Req_DataInReady;
    logic [FEDWidth-1:0] Req_DataOut;
    logic [NumReq-1:0] Req_DataOutValid, Req_DataOutReady;
    logic [1:0] Cmd;
    logic [ORAMU-1:0] PAddr;
    logic CmdValid, CmdReady;
    logic [FEDWidth-1:0] DataIn;
    logic DataInValid, DataInReady;
    logic [FEDWidth-1:0] DataOut;
    logic DataOutValid, DataOutReady;
    logic [NumReq-1:0] Grant;
    logic Busy;

    int errors = 0;
    int checks = 0;

    oram_frontend_arbiter #(.NumReq(NumReq), .ORAMB(ORAMB), .ORAMU(ORAMU), .FEDWidth(FEDWidth)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req_Cmd(Req_Cmd), .Req_PAddr(Req_PAddr), .Req_CmdValid(Req_CmdValid), .Req_CmdReady(Req_CmdReady),
        .Req_DataIn(Req_DataIn), .Req_DataInValid(Req_DataInValid), .Req_DataInReady(Req_DataInReady),
        .Req_DataOut(Req_DataOut), .Req_DataOutValid(Req_DataOutValid), .Req_DataOutReady(Req_DataOutReady),
        .Cmd(Cmd), .PAddr(PAddr), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
        .Grant(Grant), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic setReq(input int r, input logic [1:0] c, input logic [31:0] a);
        Req_Cmd[r*2 +: 2] = c;
        Req_PAddr[r*ORAMU +: ORAMU] = a;
        Req_CmdValid[r] = 1'b1;
    endtask

    task automatic doCmd(input logic [1:0] c, input logic [31:0] a, input logic [1:0] g);
        #1;
        chk("cmd_phase", {Grant, Busy, CmdValid, Cmd, PAddr}, {g, 1'b1, 1'b1, c, a});
        CmdReady = 1'b1;
        tick();
        CmdReady = 1'b0;
    endtask

    task automatic rdBeats(input int r, input logic [63:0] base);
        logic [1:0] oh;
        oh = 2'b01 << r;
        Req_DataOutReady = 2'b11;
        DataOutValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            DataOut = base + 64'(i);
            #1;
            chk("rd_beat", {Req_CmdReady, Req_DataOutValid, DataOutReady, Req_DataOut},
                {2'b00, oh, 1'b1, base + 64'(i)});
            tick();
        end
        DataOutValid = 1'b0;
    endtask

    initial begin
        int beat;
        logic rdy;
        Reset = 1'b0;
        Req_Cmd = '0;
        Req_PAddr = '0;
        Req_CmdValid = '0;
        Req_DataIn = '0;
        Req_DataInValid = '0;
        Req_DataOutReady = '0;
        CmdReady = 1'b0;
        DataInReady = 1'b0;
        DataOut = '0;
        DataOutValid = 1'b0;

        // 1: reset then R0 Append addr 5 with 8 write beats 5..12
        repeat (5) tick();
        chk("reset_state", {Grant, Busy, CmdValid, Cmd, PAddr, Req_CmdReady, DataInValid, DataOutReady},
            {2'b00, 1'b0, 1'b0, 2'd0, 32'd0, 2'b00, 1'b0, 1'b0});
        Reset = 1'b1;
        tick();
        setReq(0, 2'd1, 32'd5);
        #1;
        chk("t1_cmdready", {Req_CmdReady, CmdValid}, {2'b01, 1'b0});
        tick();
        Req_CmdValid = '0;
        doCmd(2'd1, 32'd5, 2'b01);
        Req_DataInValid = 2'b01;
        DataInReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Req_DataIn[63:0] = 64'd5 + 64'(i);
            #1;
            chk("t1_wr_beat", {DataInValid, Req_DataInReady, Grant, Busy, DataIn},
                {1'b1, 2'b01, 2'b01, 1'b1, 64'd5 + 64'(i)});
            tick();
        end
        Req_DataInValid = '0;
        DataInReady = 1'b0;
        #1;
        chk("t1_done", {Busy, Grant, DataInValid, Req_DataInReady}, {1'b0, 2'b00, 1'b0, 2'b00});

        // 2: both Read right after reset; R0 first, R1 right after R0's last beat
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        setReq(0, 2'd2, 32'h10);
        setReq(1, 2'd2, 32'h20);
        #1;
        chk("t2_first_pick", Req_CmdReady, 2'b01);
        tick();
        Req_CmdValid[0] = 1'b0;
        doCmd(2'd2, 32'h10, 2'b01);
        rdBeats(0, 64'hA0);
        #1;
        chk("t2_second_pick", {Busy, Req_CmdReady}, {1'b0, 2'b10});
        tick();
        Req_CmdValid = '0;
        doCmd(2'd2, 32'h20, 2'b10);
        rdBeats(1, 64'hC0);

        // 3: continuous Read streams alternate 0,1,0,1,0,1
        setReq(0, 2'd2, 32'h30);
        setReq(1, 2'd2, 32'h31);
        for (int a = 0; a < 6; a++) begin
            #1;
            chk("t3_rr_pick", Req_CmdReady, (a % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            if (a == 5) Req_CmdValid = '0;
            doCmd(2'd2, (a % 2 == 1) ? 32'h31 : 32'h30, (a % 2 == 1) ? 2'b10 : 2'b01);
            rdBeats(a % 2, 64'h100 * 64'(a));
        end

        // 4: R1 ReadRmv with its ready toggling; R0's ready is inverted to catch wrong steering
        setReq(1, 2'd3, 32'h44);
        #1;
        chk("t4_pick", Req_CmdReady, 2'b10);
        tick();
        Req_CmdValid = '0;
        doCmd(2'd3, 32'h44, 2'b10);
        beat = 0;
        DataOutValid = 1'b1;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            rdy = (c % 2 == 0);
            Req_DataOutReady = {rdy, ~rdy};
            DataOut = 64'hB0 + 64'(beat);
            #1;
            chk("t4_rd_toggle", {DataOutReady, Req_DataOutValid, Busy, Req_DataOut},
                {rdy, 2'b10, 1'b1, 64'hB0 + 64'(beat)});
            if (rdy) beat++;
            tick();
        end
        DataOutValid = 1'b0;
        chk("t4_beat_count", 128'(beat), 128'd8);
        #1;
        chk("t4_done", {Busy, Grant}, {1'b0, 2'b00});

        // 5: CmdReady held low 20 cycles; command stays stable and no write handshake happens
        setReq(0, 2'd0, 32'h77);
        #1;
        chk("t5_pick", Req_CmdReady, 2'b01);
        tick();
        Req_CmdValid = '0;
        Req_DataInValid = 2'b01;
        DataInReady = 1'b1;
        Req_DataIn[63:0] = 64'h55;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("t5_cmd_stall", {CmdValid, Cmd, PAddr, DataInValid, Req_DataInReady, Grant},
                {1'b1, 2'd0, 32'h77, 1'b0, 2'b00, 2'b01});
            tick();
        end
        CmdReady = 1'b1;
        tick();
        CmdReady = 1'b0;

        // 6: reset after write beat 3 aborts; priority restarts at requester 0
        for (int i = 0; i < 3; i++) begin
            Req_DataIn[63:0] = 64'h300 + 64'(i);
            #1;
            chk("t6_wr_beat", {DataInValid, Req_DataInReady, DataIn}, {1'b1, 2'b01, 64'h300 + 64'(i)});
            tick();
        end
        Reset = 1'b0;
        setReq(0, 2'd2, 32'h90);
        DataOutValid = 1'b1;
        Req_DataOutReady = 2'b11;
        tick();
        chk("t6_reset_outputs",
            {Grant, Busy, CmdValid, Req_CmdReady, DataInValid, Req_DataInReady, DataIn, Cmd, PAddr,
             Req_DataOutValid, DataOutReady},
            {2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 64'd0, 2'd0, 32'd0, 2'b00, 1'b0});
        chk("t6_reset_dataout", Req_DataOut, 64'd0);
        Reset = 1'b1;
        Req_CmdValid = '0;
        Req_DataInValid = '0;
        DataInReady = 1'b0;
        DataOutValid = 1'b0;
        tick();
        setReq(0, 2'd2, 32'h90);
        setReq(1, 2'd2, 32'h91);
        #1;
        chk("t6_prio_restart", Req_CmdReady, 2'b01);
        Req_CmdValid[0] = 1'b0;
        #1;
        chk("t6_skip_dropped", Req_CmdReady, 2'b10);
        tick();
        Req_CmdValid = '0;
        doCmd(2'd2, 32'h91, 2'b10);
        rdBeats(1, 64'hD0);
        #1;
        chk("t6_done", {Busy, Grant}, {1'b0, 2'b00});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
